// File: rtl/code_entry_pkg.sv
// Shared types and default sizing for the key-sequence capture block.
package code_entry_pkg;

  localparam int N_SYM_DEF   = 4;
  localparam int MAX_LEN_DEF = 7;
  localparam int MIN_LEN_DEF = 4;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    FULL  = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/code_entry_if.sv
// Button-side inputs and committed-sequence outputs of one player's capture block.
interface code_entry_if #(
  parameter int N_SYM   = code_entry_pkg::N_SYM_DEF,
  parameter int MAX_LEN = code_entry_pkg::MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic [N_SYM-1:0]         key;
  logic                     enter;
  logic                     clear;
  logic                     ack;
  logic [N_SYM*MAX_LEN-1:0] masks;
  logic [LEN_W-1:0]         seq_len;
  logic                     full;
  logic                     done;
  logic                     err;

  modport master (
    output key, enter, clear, ack,
    input  masks, seq_len, full, done, err
  );

  modport slave (
    input  key, enter, clear, ack,
    output masks, seq_len, full, done, err
  );
endinterface

// File: rtl/code_entry_edge_rise.sv
// Rising-edge detector; history resets to all-ones so levels held through reset never count.
module edge_rise #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lvl_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;

  // Previous-level history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= lvl_i;
    end
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/code_entry.sv
// Per-player key-sequence capture: records presses as per-symbol position masks and
// commits them to the scoring logic through a done/ack handshake.
module code_entry
  import code_entry_pkg::*;
#(
  parameter int N_SYM   = N_SYM_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic          clk,
  input logic          rst,
  code_entry_if.slave  bus
);

  state_e                   state_q, state_d;
  logic [N_SYM*MAX_LEN-1:0] masks_q, masks_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     full_q, full_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [N_SYM+1:0]         rise_s;
  logic [N_SYM-1:0]         key_rise_s;
  logic                     enter_rise_s;
  logic                     clear_rise_s;
  logic [MAX_LEN-1:0]       pos_s;

  function automatic logic multi_hot(input logic [N_SYM-1:0] v);
    return (v & (v - N_SYM'(1))) != '0;
  endfunction

  edge_rise #(.WIDTH(N_SYM + 2)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  ({bus.clear, bus.enter, bus.key}),
    .rise_o (rise_s)
  );

  assign key_rise_s   = rise_s[N_SYM-1:0];
  assign enter_rise_s = rise_s[N_SYM];
  assign clear_rise_s = rise_s[N_SYM+1];
  assign pos_s        = MAX_LEN'(1) << len_q;

  // State, sequence and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTRY;
      masks_q <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      masks_q <= masks_d;
      len_q   <= len_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state; priority clear > ack > enter > key
  always_comb begin
    state_d = state_q;
    masks_d = masks_q;
    len_d   = len_q;
    done_d  = done_q;
    err_d   = 1'b0;
    if (clear_rise_s) begin
      state_d = ENTRY;
      masks_d = '0;
      len_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ENTRY, FULL: begin
          if (enter_rise_s) begin
            // A simultaneous key edge is discarded; enter judges the existing length
            if (len_q >= LEN_W'(MIN_LEN)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_rise_s != '0) begin
            if ((state_q == FULL) || multi_hot(key_rise_s)) begin
              err_d = 1'b1;
            end else begin
              for (int s = 0; s < N_SYM; s++) begin
                masks_d[s*MAX_LEN +: MAX_LEN] = masks_q[s*MAX_LEN +: MAX_LEN] |
                                                (key_rise_s[s] ? pos_s : MAX_LEN'(0));
              end
              len_d = len_q + LEN_W'(1);
              if (len_d == LEN_W'(MAX_LEN)) begin
                state_d = FULL;
              end else begin
                state_d = ENTRY;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        DONE: begin
          if (bus.ack) begin
            state_d = ENTRY;
            masks_d = '0;
            len_d   = '0;
            done_d  = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = ENTRY;
          masks_d = '0;
          len_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
    full_d = (len_d == LEN_W'(MAX_LEN));
  end

  assign bus.masks   = masks_q;
  assign bus.seq_len = len_q;
  assign bus.full    = full_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_code_entry.sv
// Directed plus randomized bench for code_entry against a sequence-queue reference model.
module tb_code_entry;

  localparam int N  = 4;
  localparam int M  = 7;
  localparam int MN = 4;
  localparam int LW = $clog2(M + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  code_entry_if #(.N_SYM(N), .MAX_LEN(M), .LEN_W(LW)) bus ();

  code_entry #(.N_SYM(N), .MAX_LEN(M), .MIN_LEN(MN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: the sequence is a list of pressed symbols
  int         seq_q[$];
  bit         m_done;
  bit         m_err;
  logic [N+1:0] m_prev;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [N*M-1:0] m_masks();
    logic [N*M-1:0] v;
    v = '0;
    foreach (seq_q[i]) v[seq_q[i]*M + i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    seq_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_prev = '1;
  endtask

  task automatic model_step();
    logic [N+1:0] lv;
    logic [N+1:0] rise;
    int nk;
    if (rst) begin
      model_reset();
      return;
    end
    lv     = {bus.clear, bus.enter, bus.key};
    rise   = lv & ~m_prev;
    m_prev = lv;
    m_err  = 1'b0;
    nk     = $countones(rise[N-1:0]);
    if (rise[N+1]) begin
      seq_q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      if (bus.ack) begin
        seq_q.delete();
        m_done = 1'b0;
      end
    end else if (rise[N]) begin
      if (seq_q.size() >= MN) m_done = 1'b1;
      else m_err = 1'b1;
    end else if (nk > 0) begin
      if (seq_q.size() == M || nk > 1) begin
        m_err = 1'b1;
      end else begin
        for (int s = 0; s < N; s++) if (rise[s]) seq_q.push_back(s);
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N*M-1:0] em;
    logic [LW-1:0]  el;
    logic           ef;
    em = m_masks();
    el = LW'(seq_q.size());
    ef = (seq_q.size() == M);
    checks++;
    assert (bus.masks === em) else begin
      errors++; $error("FAIL %s masks got %h exp %h", tag, bus.masks, em);
    end
    checks++;
    assert (bus.seq_len === el) else begin
      errors++; $error("FAIL %s seq_len got %0d exp %0d", tag, bus.seq_len, el);
    end
    checks++;
    assert (bus.full === ef) else begin
      errors++; $error("FAIL %s full got %b exp %b", tag, bus.full, ef);
    end
    checks++;
    assert (bus.done === m_done) else begin
      errors++; $error("FAIL %s done got %b exp %b", tag, bus.done, m_done);
    end
    checks++;
    assert (bus.err === m_err) else begin
      errors++; $error("FAIL %s err got %b exp %b", tag, bus.err, m_err);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check(tag);
  endtask

  task automatic press(input int s, input string tag);
    bus.key[s] = 1'b1;
    cyc(tag);
    bus.key[s] = 1'b0;
    cyc(tag);
  endtask

  task automatic pulse_enter(input string tag);
    bus.enter = 1'b1;
    cyc(tag);
    bus.enter = 1'b0;
    cyc(tag);
  endtask

  task automatic pulse_ack(input string tag);
    bus.ack = 1'b1;
    cyc(tag);
    bus.ack = 1'b0;
    cyc(tag);
  endtask

  logic [N*M-1:0] exp_m;

  initial begin
    rst       = 1'b1;
    bus.key   = '0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    bus.ack   = 1'b0;
    model_reset();
    #12;
    check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_reset");

    // Four presses then enter
    press(0, "p0");
    press(2, "p2");
    press(3, "p3");
    press(1, "p1");
    bus.enter = 1'b1;
    cyc("enter4");
    exp_m = '0;
    exp_m[0] = 1'b1; exp_m[15] = 1'b1; exp_m[23] = 1'b1; exp_m[10] = 1'b1;
    checks++;
    assert (bus.masks === exp_m && bus.done === 1'b1 && bus.seq_len === LW'(4)) else begin
      errors++; $error("FAIL seq4 masks got %h exp %h done %b", bus.masks, exp_m, bus.done);
    end
    bus.enter = 1'b0;
    cyc("enter4_rel");

    // DONE ignores keys and enter, then ack
    press(1, "done_key");
    pulse_enter("done_enter");
    pulse_ack("ack1");
    checks++;
    assert (bus.seq_len === LW'(0) && bus.masks === '0 && bus.done === 1'b0) else begin
      errors++; $error("FAIL ack_clear seq_len got %0d exp 0 done %b", bus.seq_len, bus.done);
    end

    // Too short, then long enough
    press(1, "s1"); press(2, "s2"); press(3, "s3");
    bus.enter = 1'b1;
    cyc("short_enter");
    checks++;
    assert (bus.err === 1'b1 && bus.done === 1'b0 && bus.seq_len === LW'(3)) else begin
      errors++; $error("FAIL short_err err got %b exp 1 seq_len %0d", bus.err, bus.seq_len);
    end
    bus.enter = 1'b0;
    cyc("short_rel");
    press(0, "s4");
    pulse_enter("enter_ok");
    pulse_ack("ack2");

    // Fill to the limit
    for (int i = 0; i < M; i++) press(0, "fill");
    exp_m = '0;
    exp_m[6:0] = 7'h7F;
    checks++;
    assert (bus.full === 1'b1 && bus.masks === exp_m) else begin
      errors++; $error("FAIL full7 masks got %h exp %h", bus.masks, exp_m);
    end
    press(0, "overflow");
    pulse_enter("full_enter");
    pulse_ack("ack3");

    // Multiple keys rise together; key plus enter together
    press(0, "m0"); press(1, "m1"); press(2, "m2"); press(3, "m3");
    bus.key = 4'b0011;
    cyc("multi");
    bus.key = 4'b0000;
    cyc("multi_rel");
    bus.key[2] = 1'b1;
    bus.enter  = 1'b1;
    cyc("key_enter");
    checks++;
    assert (bus.done === 1'b1 && bus.seq_len === LW'(4) && bus.err === 1'b0) else begin
      errors++; $error("FAIL key_enter done got %b exp 1 seq_len %0d", bus.done, bus.seq_len);
    end
    bus.key   = '0;
    bus.enter = 1'b0;
    cyc("key_enter_rel");
    pulse_ack("ack4");

    // Clear mid-entry
    for (int i = 0; i < 5; i++) press(i % N, "pre_clear");
    bus.clear = 1'b1;
    cyc("clear");
    bus.clear = 1'b0;
    cyc("clear_rel");

    // Key held across an asynchronous reset
    press(3, "pre_rst");
    bus.key[1] = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst");
    cyc("in_rst");
    rst = 1'b0;
    cyc("held1");
    cyc("held2");
    bus.key[1] = 1'b0;
    cyc("held_rel");

    // Randomized levels
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < N; s++) if ($urandom_range(0, 3) == 0) bus.key[s] = ~bus.key[s];
      bus.enter = ($urandom_range(0, 7) == 0);
      bus.clear = ($urandom_range(0, 59) == 0);
      bus.ack   = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      cyc("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_entry.md
# code_entry

Parametrised key-sequence capture block for the guess-number game. Watches N_SYM synchronised push-button levels plus enter/clear, and records each rising-edge press as a bit in a per-symbol position mask: bit p of symbol s's mask means the p-th press was s. Adds on-chip edge detection, length limits, error reporting and a done/ack handshake toward the comparison/scoring logic. Two instances, one per player, feed the match logic.

## Interface
Parameters:
- N_SYM, 4: number of symbol keys.
- MAX_LEN, 7: maximum sequence length (mask width per symbol).
- MIN_LEN, 4: minimum length accepted by enter; 1 ≤ MIN_LEN ≤ MAX_LEN.
- LEN_W, $clog2(MAX_LEN+1): derived width of seq_len; not overridden.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key  in  N_SYM  synchronised key levels, bit s = symbol s.
- enter  in  1  synchronised commit level.
- clear  in  1  synchronised wipe level.
- ack  in  1  consumer accepts committed sequence (level, sampled only in DONE).
- masks  out  N_SYM*MAX_LEN  flattened masks, bit s*MAX_LEN+p.
- seq_len  out  LEN_W  presses recorded, 0..MAX_LEN.
- full  out  1  seq_len == MAX_LEN.
- done  out  1  sequence committed; held until ack or clear.
- err  out  1  one-cycle pulse on a rejected event.

## Operation
- Rising edges of key, enter and clear are detected internally (level high now, low at previous edge). Previous-level registers reset to all-ones, so inputs held through reset never count as presses.
- States: ENTRY, FULL, DONE.
- ENTRY, exactly one key edge: set masks[s*MAX_LEN+seq_len], seq_len+1. When new seq_len == MAX_LEN, go to FULL.
- ENTRY, two or more key edges in the same cycle: nothing recorded, err pulses.
- ENTRY or FULL, enter edge: if seq_len ≥ MIN_LEN, go to DONE with done=1. Otherwise err pulses and the state is kept.
- FULL, any key edge: ignored, err pulses.
- DONE: key and enter edges are ignored with no err. ack high clears masks, seq_len and done and returns to ENTRY.
- Clear edge, any state: masks=0, seq_len=0, done=0, go to ENTRY. No err.
- Priority within a cycle: clear > ack > enter > key. A key edge in the same cycle as an enter edge is discarded, and enter is evaluated on the existing seq_len. That discard does not raise err.
- masks has at most one bit set per position p across all symbols. Bits at positions ≥ seq_len are always 0.

## Timing
- Reset: masks=0, seq_len=0, full=0, done=0, err=0, state ENTRY, edge registers all-ones. Reset is asynchronous and takes effect immediately mid-sequence.
- An edge detected at clock edge k has its effect registered at edge k: masks, seq_len, full, done and err are valid after edge k. Latency is 1 cycle from the input level change being sampled.
- err is high for exactly the one cycle following the offending edge.
- ack is level-sensitive in DONE. done falls after the first edge with ack=1. ack outside DONE is ignored.
- All outputs are registered directly; no combinational input-to-output paths.

## Structure
- Package code_entry_pkg: state enum typedef (ENTRY, FULL, DONE) and the default parameter constants.
- Sub-module edge_rise: parameterised-width rising-edge detector with reset value all-ones. One instance covers {clear, enter, key}.
- FSM, masks and counter live in code_entry.

## Test plan
- Defaults; press keys 0, 2, 3, 1 one cycle apart, then enter → masks bits 0, 15, 23, 10 set, seq_len=4, done=1 one cycle after enter.
- Press 3 keys, then enter → err pulses one cycle, done=0, seq_len stays 3. A 4th press followed by enter → done=1.
- 7 presses of key 0 → full=1, masks[6:0]=7'h7F. An 8th press → err pulse, masks unchanged. Enter → done.
- key=4'b0011 rising in the same cycle → err pulse, seq_len unchanged. key 2 and enter rising together with seq_len=4 → done=1, seq_len=4.
- In DONE: key and enter edges change nothing. ack=1 → done=0, masks=0, seq_len=0 next cycle. Clear at seq_len=5 → all zero, no err.
- Hold key 1 high across the rst pulse and release rst mid-sequence → no press recorded. All outputs are zero during rst.
